// File: rtl/marv32_store_buffer.sv
// marv32 store buffer: DEPTH-entry FIFO of lane-placed stores drained as
// pipelined AHB-Lite NONSEQ writes, with wait-state and ERROR handling.
module marv32_store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   iadder_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              mem_wr_req_in,
    output logic              store_ready_out,
    output logic              empty_out,
    output logic              misaligned_out,
    output logic              bus_err_out,
    output logic [XLEN-1:0]   ahb_haddr_out,
    output logic              ahb_hwrite_out,
    output logic [2:0]        ahb_hsize_out,
    output logic [1:0]        ahb_htrans_out,
    output logic [XLEN-1:0]   ahb_hwdata_out,
    output logic [XLEN/8-1:0] wr_mask_out,
    input  logic              ahb_hready_in,
    input  logic              ahb_hresp_in
);
    localparam int BW = XLEN / 8;
    localparam int LW = $clog2(BW);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] addr_mem_q [DEPTH];
    logic [1:0]      size_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [BW-1:0]   mask_mem_q [DEPTH];

    logic [PW-1:0]   wptr_q, wptr_d, aptr_q, aptr_d, dptr_q, dptr_d;
    logic [CW-1:0]   count_q, count_d, pend_q, pend_d;
    logic            dphase_q, dphase_d;
    logic            mis_q, mis_d, berr_q, berr_d;
    logic [XLEN-1:0] haddr_q, haddr_d;
    logic [1:0]      hsize_q, hsize_d;

    logic            legal_w;
    logic [XLEN-1:0] lo_data_w, place_data_w;
    logic [BW-1:0]   lo_mask_w, place_mask_w;
    logic [LW-1:0]   lane_w;
    logic            push_w, reject_w, err_w, issue_w, aacc_w, pop_w;

    assign lane_w = iadder_in[LW-1:0];

    always_comb begin
        legal_w   = ~funct3_in[2];
        lo_data_w = '0;
        lo_mask_w = '0;
        case (funct3_in[1:0])
            2'd0: begin
                lo_data_w = XLEN'(rs2_in[7:0]);
                lo_mask_w = BW'(1);
            end
            2'd1: begin
                lo_data_w = XLEN'(rs2_in[15:0]);
                lo_mask_w = BW'(2'b11);
                if (iadder_in[0]) legal_w = 1'b0;
            end
            2'd2: begin
                lo_data_w = XLEN'(rs2_in[31:0]);
                lo_mask_w = BW'(4'hF);
                if (iadder_in[1:0] != 2'b00) legal_w = 1'b0;
            end
            default: begin
                lo_data_w = rs2_in;
                lo_mask_w = '1;
                if (XLEN != 64 || iadder_in[2:0] != 3'b000) legal_w = 1'b0;
            end
        endcase
        place_data_w = lo_data_w << {lane_w, 3'b000};
        place_mask_w = lo_mask_w << lane_w;
    end

    assign store_ready_out = (count_q < CW'(DEPTH));
    assign empty_out       = (count_q == '0) && !dphase_q;

    assign push_w   = mem_wr_req_in && store_ready_out && legal_w;
    assign reject_w = mem_wr_req_in && store_ready_out && !legal_w;
    // An ERROR response in the data phase withdraws any overlapping address phase.
    assign err_w    = dphase_q && ahb_hresp_in;
    assign issue_w  = (pend_q != '0) && !err_w;
    assign aacc_w   = issue_w && ahb_hready_in;
    assign pop_w    = dphase_q && ahb_hready_in;

    assign ahb_htrans_out = issue_w ? 2'b10 : 2'b00;
    assign ahb_hwrite_out = issue_w;
    assign ahb_haddr_out  = issue_w ? addr_mem_q[aptr_q] : haddr_q;
    assign ahb_hsize_out  = {1'b0, (issue_w ? size_mem_q[aptr_q] : hsize_q)};
    assign ahb_hwdata_out = dphase_q ? data_mem_q[dptr_q] : '0;
    assign wr_mask_out    = dphase_q ? mask_mem_q[dptr_q] : '0;
    assign misaligned_out = mis_q;
    assign bus_err_out    = berr_q;

    always_comb begin
        wptr_d   = push_w ? wptr_q + PW'(1) : wptr_q;
        aptr_d   = aacc_w ? aptr_q + PW'(1) : aptr_q;
        dptr_d   = pop_w  ? dptr_q + PW'(1) : dptr_q;
        count_d  = count_q + CW'(push_w) - CW'(pop_w);
        pend_d   = pend_q + CW'(push_w) - CW'(aacc_w);
        dphase_d = aacc_w ? 1'b1 : (pop_w ? 1'b0 : dphase_q);
        mis_d    = reject_w;
        berr_d   = pop_w && ahb_hresp_in;
        haddr_d  = ahb_haddr_out;
        hsize_d  = ahb_hsize_out[1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wptr_q   <= '0;
            aptr_q   <= '0;
            dptr_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            dphase_q <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            haddr_q  <= '0;
            hsize_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            aptr_q   <= aptr_d;
            dptr_q   <= dptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            dphase_q <= dphase_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
        end
    end

    // Payload storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_in) begin
        if (push_w) begin
            addr_mem_q[wptr_q] <= iadder_in;
            size_mem_q[wptr_q] <= funct3_in[1:0];
            data_mem_q[wptr_q] <= place_data_w;
            mask_mem_q[wptr_q] <= place_mask_w;
        end
    end
endmodule

// File: tb/tb_marv32_store_buffer.sv
// Scoreboard bench for marv32_store_buffer: XLEN=32 instance checked by a
// beat monitor, XLEN=64 instance checked with directed samples.
module tb_marv32_store_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, rs2 = '0;
    logic        req = 1'b0, hready = 1'b1, hresp = 1'b0;
    logic        ready, empty, mis, berr, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  mask;

    logic [2:0]  f3_6 = '0;
    logic [63:0] addr_6 = '0, rs2_6 = '0;
    logic        req_6 = 1'b0;
    logic        ready_6, empty_6, mis_6, berr_6, hwrite_6;
    logic [63:0] haddr_6, hwdata_6;
    logic [2:0]  hsize_6;
    logic [1:0]  htrans_6;
    logic [7:0]  mask_6;

    marv32_store_buffer #(.XLEN(32), .DEPTH(4)) dut32 (
        .clk_in(clk), .rst_n_in(rst_n), .funct3_in(f3), .iadder_in(addr), .rs2_in(rs2),
        .mem_wr_req_in(req), .store_ready_out(ready), .empty_out(empty),
        .misaligned_out(mis), .bus_err_out(berr), .ahb_haddr_out(haddr),
        .ahb_hwrite_out(hwrite), .ahb_hsize_out(hsize), .ahb_htrans_out(htrans),
        .ahb_hwdata_out(hwdata), .wr_mask_out(mask), .ahb_hready_in(hready),
        .ahb_hresp_in(hresp));

    marv32_store_buffer #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk_in(clk), .rst_n_in(rst_n), .funct3_in(f3_6), .iadder_in(addr_6), .rs2_in(rs2_6),
        .mem_wr_req_in(req_6), .store_ready_out(ready_6), .empty_out(empty_6),
        .misaligned_out(mis_6), .bus_err_out(berr_6), .ahb_haddr_out(haddr_6),
        .ahb_hwrite_out(hwrite_6), .ahb_hsize_out(hsize_6), .ahb_htrans_out(htrans_6),
        .ahb_hwdata_out(hwdata_6), .wr_mask_out(mask_6), .ahb_hready_in(1'b1),
        .ahb_hresp_in(1'b0));

    typedef struct {
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
        logic [3:0]  m;
    } beat_t;

    beat_t expq[$];
    int tests = 0, fails = 0;
    int beats = 0, run = 0, runmax = 0, mis_cnt = 0, berr_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] d, input logic [3:0] m);
        beat_t b;
        b.a = a; b.s = s; b.d = d; b.m = m;
        expq.push_back(b);
    endtask

    // Monitor: tracks the bus pipeline independently and scores each completed beat.
    logic        mon_dph = 1'b0, sv_wr = 1'b0;
    logic [31:0] sv_addr = '0;
    logic [2:0]  sv_size = '0;
    beat_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_dph = 1'b0;
        end else begin
            if (mon_dph && hready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {32'h0, sv_addr}, 64'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("beat_haddr", sv_addr, e.a);
                    chk("beat_hsize", sv_size, e.s);
                    chk("beat_hwrite", sv_wr, 1'b1);
                    chk("beat_hwdata", hwdata, e.d);
                    chk("beat_mask", mask, e.m);
                end
            end
            if (!(mon_dph && !hready)) begin
                mon_dph = (htrans == 2'b10) && hready;
                if (mon_dph) begin
                    sv_addr = haddr; sv_size = hsize; sv_wr = hwrite; beats++;
                end
            end
            if (htrans == 2'b10) begin
                run++;
                if (run > runmax) runmax = run;
            end else run = 0;
            if (mis) mis_cnt++;
            if (berr) berr_cnt++;
        end
    end

    task automatic clr_counts();
        beats = 0; run = 0; runmax = 0; mis_cnt = 0; berr_cnt = 0;
    endtask

    // Called at posedge+1; holds the request until accepted (bounded).
    task automatic store32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bit acc = 1'b0;
        f3 = f; addr = a; rs2 = d; req = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk); acc = ready;
            @(posedge clk); #1;
        end
        req = 1'b0;
        if (!acc) chk("store_timeout", 0, 1);
    endtask

    task automatic wait_empty(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); got = empty;
        end
        chk(name, got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_misaligned", mis, 1'b0);
        chk("rst_bus_err", berr, 1'b0);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hsize", hsize, 3'b000);
        chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_mask", mask, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte lanes, zero-wait: four back-to-back sb stores.
        clr_counts();
        expect_beat(32'h100, 3'd0, 32'h0000_0044, 4'b0001);
        expect_beat(32'h101, 3'd0, 32'h0000_3300, 4'b0010);
        expect_beat(32'h102, 3'd0, 32'h0022_0000, 4'b0100);
        expect_beat(32'h103, 3'd0, 32'h1100_0000, 4'b1000);
        store32(3'b000, 32'h100, 32'h1122_3344);
        store32(3'b000, 32'h101, 32'h1122_3333);
        store32(3'b000, 32'h102, 32'h1122_2222);
        store32(3'b000, 32'h103, 32'h1111_1111);
        wait_empty("sb_empty");
        chk("sb_beats", beats, 4);
        chk("sb_back_to_back", runmax, 4);
        chk("sb_queue_drained", expq.size(), 0);

        // Backpressure and full.
        clr_counts();
        hready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h300 + 32'(4 * i), 3'd2, 32'hA000_0000 + 32'(i), 4'hF);
            store32(3'b010, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        f3 = 3'b010; addr = 32'h310; rs2 = 32'hA000_0004; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready_low", ready, 1'b0);
            chk("full_no_empty", empty, 1'b0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        hready = 1'b1;
        wait_empty("full_empty");
        chk("full_beats", beats, 4);
        chk("full_queue_drained", expq.size(), 0);

        // Misaligned / illegal stores.
        clr_counts();
        f3 = 3'b001; addr = 32'h201; rs2 = 32'h5555_5555; req = 1'b1;
        @(posedge clk); #1;
        f3 = 3'b010; addr = 32'h202;
        @(posedge clk); #1;
        f3 = 3'b011; addr = 32'h200;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mis_pulses", mis_cnt, 3);
        chk("mis_no_beat", beats, 0);
        chk("mis_empty", empty, 1'b1);
        chk("mis_htrans", htrans, 2'b00);
        @(posedge clk); #1;

        // ERROR response on the first of two queued words.
        clr_counts();
        hready = 1'b0;
        expect_beat(32'h400, 3'd2, 32'h1234_5678, 4'hF);
        expect_beat(32'h404, 3'd2, 32'h9ABC_DEF0, 4'hF);
        store32(3'b010, 32'h400, 32'h1234_5678);
        store32(3'b010, 32'h404, 32'h9ABC_DEF0);
        hready = 1'b1;
        @(posedge clk); #1;
        hready = 1'b0; hresp = 1'b1;
        @(negedge clk);
        chk("err_idle", htrans, 2'b00);
        chk("err_hwdata_held", hwdata, 32'h1234_5678);
        @(posedge clk); #1;
        hready = 1'b1; hresp = 1'b1;
        @(posedge clk); #1;
        hresp = 1'b0;
        @(negedge clk);
        chk("err_bus_err", berr, 1'b1);
        chk("err_reissue_htrans", htrans, 2'b10);
        chk("err_reissue_haddr", haddr, 32'h404);
        @(posedge clk); #1;
        wait_empty("err_empty");
        chk("err_bus_err_once", berr_cnt, 1);
        chk("err_queue_drained", expq.size(), 0);

        // XLEN=64 double and upper-lane word.
        f3_6 = 3'b011; addr_6 = 64'h1000; rs2_6 = 64'hA1B2_C3D4_E5F6_0718; req_6 = 1'b1;
        @(posedge clk); #1;
        f3_6 = 3'b010; addr_6 = 64'h1004; rs2_6 = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        chk("x64_sd_htrans", htrans_6, 2'b10);
        chk("x64_sd_hsize", hsize_6, 3'd3);
        chk("x64_sd_haddr", haddr_6, 64'h1000);
        @(posedge clk); #1;
        req_6 = 1'b0;
        @(negedge clk);
        chk("x64_sd_hwdata", hwdata_6, 64'hA1B2_C3D4_E5F6_0718);
        chk("x64_sd_mask", mask_6, 8'hFF);
        chk("x64_sw_hsize", hsize_6, 3'd2);
        chk("x64_sw_haddr", haddr_6, 64'h1004);
        @(negedge clk);
        chk("x64_sw_hwdata", hwdata_6, 64'hDEAD_BEEF_0000_0000);
        chk("x64_sw_mask", mask_6, 8'hF0);
        @(negedge clk);
        chk("x64_empty", empty_6, 1'b1);
        @(posedge clk); #1;

        // Reset with entries queued and a data phase active.
        clr_counts();
        hready = 1'b0;
        for (int i = 0; i < 4; i++) store32(3'b010, 32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        expect_beat(32'h500, 3'd2, 32'hB000_0000, 4'hF);
        hready = 1'b1;
        @(posedge clk); #1;
        hready = 1'b0;
        @(negedge clk);
        chk("rstmid_dphase_mask", mask, 4'hF);
        chk("rstmid_nonseq", htrans, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_htrans", htrans, 2'b00);
        chk("rstmid_mask", mask, 4'h0);
        chk("rstmid_hwdata", hwdata, 32'h0);
        chk("rstmid_empty", empty, 1'b1);
        chk("rstmid_ready", ready, 1'b1);
        expq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1; hready = 1'b1;
        clr_counts();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rstmid_no_beats", beats, 0);
        chk("rstmid_empty_after", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/marv32_store_buffer.md
# marv32_store_buffer

Parametrised AHB-Lite store path for the marv32 core, the next generation of the combinational store unit. It accepts stores from the execute stage into a DEPTH-entry FIFO. For each store it builds lane-placed write data and byte strobes, and it issues pipelined AHB-Lite write transfers with wait-state and error-response handling. Misaligned or illegal stores are rejected at the input, so the core can keep issuing while earlier stores drain.

## Interface
- XLEN, 32: data/address width; legal values are 32 and 64.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.

Ports:
- clk_in  input  1  core clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous reset, active-low.
- funct3_in  input  3  store size: [1:0] = 00 byte, 01 half, 10 word, 11 double. Double is legal only when XLEN=64. Bit 2 must be 0.
- iadder_in  input  XLEN  store byte address.
- rs2_in  input  XLEN  store data, right-justified.
- mem_wr_req_in  input  1  store request; sampled when store_ready_out=1.
- store_ready_out  output  1  FIFO can accept a store; equals count < DEPTH.
- empty_out  output  1  FIFO empty and no data phase outstanding.
- misaligned_out  output  1  one-cycle pulse: the request was rejected as misaligned or illegal.
- bus_err_out  output  1  one-cycle pulse: a write completed with an ERROR response.
- ahb_haddr_out  output  XLEN  byte address; not forced to alignment.
- ahb_hwrite_out  output  1  1 during every NONSEQ beat, 0 when IDLE.
- ahb_hsize_out  output  3  {1'b0, size}.
- ahb_htrans_out  output  2  2'b10 NONSEQ or 2'b00 IDLE only.
- ahb_hwdata_out  output  XLEN  lane-placed data of the current data phase.
- wr_mask_out  output  XLEN/8  byte strobes of the current data phase.
- ahb_hready_in  input  1  slave ready.
- ahb_hresp_in  input  1  slave error.

## Operation
- **Accept rule:** a store is accepted on a cycle where mem_wr_req_in=1 and store_ready_out=1.
- **Alignment check:** the store is legal if iadder_in[k-1:0]=0 for k = log2(bytes), and funct3_in[2]=0, and the size is not double when XLEN=32.
  - Legal: the entry {addr, size, data, mask} is pushed.
  - Illegal: nothing is pushed, and misaligned_out pulses high in the next cycle.
- **Data placement:** data = rs2 low (8·bytes) bits, shifted left by 8·addr[log2(XLEN/8)-1:0]; all other lanes are 0.
- **Strobes:** the mask has ones for exactly the bytes written. A 32-bit word sets all 4 bits; a 64-bit double sets all 8 bits.
- **Pointers:** the FIFO has three pointers.
  - Write pointer: next free entry.
  - Address pointer: next entry to issue.
  - Data pointer: entry in its data phase.
  - Count includes entries in address or data phase. All pointers wrap modulo DEPTH.
- **Address phase:** when an un-issued entry exists and no error is in progress:
  - Drive htrans=NONSEQ, plus haddr, hsize and hwrite=1, from the address-pointer entry.
  - The phase is accepted when ahb_hready_in=1 on the same edge; the address pointer then advances and the entry enters its data phase.
  - Otherwise htrans=IDLE, and haddr/hsize hold their last values.
- **Data phase:** a dphase_valid register marks the data phase.
  - hwdata and wr_mask come from the data-pointer entry; both are 0 when no data phase is active.
  - On hready=1 the entry pops: count decrements and the data pointer advances.
  - The next entry's address phase overlaps this data phase, giving back-to-back NONSEQ beats.
- **Error response, first cycle:** in a data phase with hresp=1 and hready=0:
  - Force htrans=IDLE that cycle; the pending address phase is withdrawn and the address pointer is not advanced.
- **Error response, second cycle:** with hresp=1 and hready=1:
  - The entry pops, bus_err_out pulses the next cycle, and issue resumes with the withdrawn entry.
- **Counting on the same edge:** push and pop on one edge leave count unchanged. When the FIFO is full, store_ready_out=0, so a same-cycle pop does not admit a push.
- **Reset:** an asserted reset discards all entries.

## Timing
- **Reset values:**
  - store_ready_out=1 and empty_out=1.
  - misaligned_out=0 and bus_err_out=0.
  - htrans=IDLE, haddr=0, hsize=0, hwrite=0.
  - hwdata=0 and wr_mask=0.
  - All pointers, the count and dphase_valid are 0.
- **Latency:** the first NONSEQ appears the cycle after acceptance (cycle N+1).
  - With zero-wait slaves the data phase is at N+2, the pop is at the end of N+2, and empty_out=1 at N+3.
- **Throughput:** one store per cycle with zero-wait slaves.
- **Wait states:** each hready=0 cycle holds the address phase, hwdata and wr_mask stable.
- **Reset mid-transfer:** on rst_n_in low, all outputs take their reset values immediately (asynchronous). No completion is signalled.
- **Status timing:**
  - store_ready_out and empty_out are combinational from registered state.
  - misaligned_out and bus_err_out are registered.

## Test plan
- **Byte lanes, XLEN=32, hready=1:**
  - Stimulus: sb of rs2=0x11223344 at addresses 0x100, 0x101, 0x102, 0x103.
  - Required response: hwdata 0x00000044, 0x00003300, 0x00220000, 0x11000000, with wr_mask 0001, 0010, 0100, 1000; hsize=0; 4 consecutive NONSEQ beats.
- **Backpressure and full, DEPTH=4:**
  - Stimulus: hready=0; issue 5 sw stores.
  - Required response: store_ready_out=0 after 4 accepts and the 5th store is held off. Releasing hready gives 4 beats in order; empty_out=1 at 2 cycles after the last hready.
- **Misaligned:**
  - Stimulus: sh at 0x201; sw at 0x202; sd with XLEN=32.
  - Required response: misaligned_out pulses once for each, with no NONSEQ and no FIFO change.
- **Error response:**
  - Stimulus: two queued sw; the slave returns ERROR on the first store (hresp=1 with hready=0, then hresp=1 with hready=1).
  - Required response: htrans=IDLE in the first error cycle and bus_err_out=1 once. The second store is then reissued as NONSEQ with the correct data.
- **XLEN=64 double:**
  - Stimulus: sd of 0xA1B2C3D4E5F60718 at 0x1000, then sw of 0xDEADBEEF at 0x1004.
  - Required response: the sd gives wr_mask=0xFF and hsize=3. The sw gives hwdata=0xDEADBEEF00000000 and wr_mask=0xF0.
- **Reset mid-operation:**
  - Stimulus: assert rst_n_in with 3 entries queued and one data phase active.
  - Required response: same-cycle htrans=IDLE, wr_mask=0, empty_out=1; no beats after release.
